// File: rtl/pio_pkg.sv
// Shared constants for the interrupt-capable PIO input port: register map and edge-capture modes.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_capture_if.sv
// Avalon-MM slave bus plus interrupt line of the PIO input port.
interface pio_in_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// Single-bit debounce filter: dout follows din only after din has differed from it for
// DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;

    // Reaching LAST on a differing cycle means this is the DEBOUNCE_CYCLES-th one, so accept now.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            dout  <= 1'b0;
        end else if (din == dout) begin
            count <= '0;
        end else if (count == LAST) begin
            dout  <= din;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pio_in_capture.sv
// PIO input port with synchroniser, per-bit edge capture, interrupt mask and level irq.
// Define PIO_IN_DEBOUNCE_EN to insert a pio_debounce_bit filter on every input line.
module pio_in_capture
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    pio_in_capture_if.slave  bus,
    input  logic [WIDTH-1:0] in_port
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (sync2[i]),
            .dout  (level[i])
        );
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d <= '0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    always_comb begin
        edges = rise;
        if (EDGE_MODE == EDGE_FALL) begin
            edges = fall;
        end else if (EDGE_MODE == EDGE_ANY) begin
            edges = rise | fall;
        end
    end

    assign wr_en = bus.chipselect & bus.write;
    assign rd_en = bus.chipselect & bus.read;
    assign wdata = bus.writedata[WIDTH-1:0];

    // New edges are OR-ed in after the W1C mask so a simultaneous set beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
        end else if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            edge_cap <= (edge_cap & ~wdata) | edges;
        end else begin
            edge_cap <= edge_cap | edges;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_en && (bus.address == ADDR_IRQMASK)) begin
            irq_mask <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd_en) begin
            case (bus.address)
                ADDR_DATA:    bus.readdata <= 32'(level);
                ADDR_RSVD:    bus.readdata <= '0;
                ADDR_IRQMASK: bus.readdata <= 32'(irq_mask);
                ADDR_EDGECAP: bus.readdata <= 32'(edge_cap);
            endcase
        end
    end

    assign bus.irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_in_capture.sv
// Drives three pio_in_capture instances (rising, falling, any-edge) from one shared bus and
// input stimulus, checking them against an edge-accumulating reference model.
module tb_pio_in_capture;
    import pio_pkg::*;

    localparam int WIDTH = 8;
    localparam int DB    = 4;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int D = DB;
`else
    localparam int D = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             read;
    logic             write;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    wire  [31:0]      rdv [3];
    wire              irqv [3];

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] model_cap [3];
    logic [WIDTH-1:0] model_mask;
    logic [WIDTH-1:0] model_level;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pio_in_capture_if bus ();
        assign bus.address    = address;
        assign bus.chipselect = chipselect;
        assign bus.read       = read;
        assign bus.write      = write;
        assign bus.writedata  = writedata;
        assign rdv[g]         = bus.readdata;
        assign irqv[g]        = bus.irq;

        pio_in_capture #(
            .WIDTH           (WIDTH),
            .EDGE_MODE       (g),
            .DEBOUNCE_CYCLES (DB)
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .bus     (bus),
            .in_port (in_port)
        );
    end

    task automatic bus_cycle(input logic [1:0] a, input logic r, input logic w, input logic [31:0] wd);
        address    = a;
        chipselect = 1'b1;
        read       = r;
        write      = w;
        writedata  = wd;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        bus_cycle(ADDR_EDGECAP, 1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) model_cap[i] = '0;
    endtask

    task automatic check_caps(input string tag);
        bus_cycle(ADDR_EDGECAP, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (rdv[i] !== 32'(model_cap[i])) begin
                mismatched++;
                $display("[TB] FAIL %s edgecap mode%0d: got %h expected %h", tag, i, rdv[i], 32'(model_cap[i]));
            end
            compared++;
            if (irqv[i] !== |(model_cap[i] & model_mask)) begin
                mismatched++;
                $display("[TB] FAIL %s irq mode%0d: got %b expected %b", tag, i, irqv[i], |(model_cap[i] & model_mask));
            end
        end
    endtask

    task automatic test_reset();
        in_port = '0;
        reset   = 1'b1;
        idle(3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_cap[i] = '0;
            compared++;
            if (rdv[i] !== 32'h0 || irqv[i] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_state mode%0d: got rd=%h irq=%b expected 0/0", i, rdv[i], irqv[i]);
            end
        end
        model_mask  = '0;
        model_level = '0;
        for (int a = 0; a < 4; a++) begin
            bus_cycle(2'(a), 1'b1, 1'b0, 32'h0);
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (rdv[i] !== 32'h0) begin
                    mismatched++;
                    $display("[TB] FAIL reset_read addr%0d mode%0d: got %h expected 00000000", a, i, rdv[i]);
                end
            end
        end
    endtask

    // Continuous DATA reads each cycle pin down the exact input-to-level and edge-to-irq latency.
    task automatic test_latency();
        logic [31:0] exp_data;
        logic        exp_irq;
        bus_cycle(ADDR_IRQMASK, 1'b0, 1'b1, 32'h04);
        model_mask = 8'h04;
        in_port    = 8'h05;
        address    = ADDR_DATA;
        chipselect = 1'b1;
        read       = 1'b1;
        for (int n = 1; n <= 4 + D; n++) begin
            @(posedge clk);
            #1;
            exp_data = (n >= 3 + D) ? 32'h05 : 32'h00;
            for (int i = 0; i < 3; i++) begin
                exp_irq = (i != EDGE_FALL) && (n >= 3 + D);
                compared++;
                if (rdv[i] !== exp_data || irqv[i] !== exp_irq) begin
                    mismatched++;
                    $display("[TB] FAIL latency edge%0d mode%0d: got rd=%h irq=%b expected rd=%h irq=%b",
                             n, i, rdv[i], irqv[i], exp_data, exp_irq);
                end
            end
        end
        chipselect = 1'b0;
        read       = 1'b0;
        model_cap[EDGE_RISE] |= 8'h05;
        model_cap[EDGE_ANY]  |= 8'h05;
        model_level = 8'h05;
        check_caps("latency");
    endtask

    task automatic test_w1c();
        bus_cycle(ADDR_EDGECAP, 1'b0, 1'b1, 32'h01);
        for (int i = 0; i < 3; i++) model_cap[i] &= ~8'h01;
        check_caps("w1c_bit0");
        bus_cycle(ADDR_EDGECAP, 1'b0, 1'b1, 32'h04);
        for (int i = 0; i < 3; i++) begin
            model_cap[i] &= ~8'h04;
            compared++;
            if (irqv[i] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL w1c_irq_drop mode%0d: got %b expected 0", i, irqv[i]);
            end
        end
        check_caps("w1c_bit2");
    endtask

    task automatic test_set_wins();
        in_port = 8'h04;
        idle(4 + D);
        clear_all();
        in_port = 8'h05;
        idle(2 + D);
        bus_cycle(ADDR_EDGECAP, 1'b0, 1'b1, 32'h01);
        model_cap[EDGE_RISE] = 8'h01;
        model_cap[EDGE_ANY]  = 8'h01;
        model_level = 8'h05;
        check_caps("set_wins");
    endtask

    task automatic test_any_edge();
        clear_all();
        in_port = model_level | 8'h08;
        idle(4 + D);
        model_cap[EDGE_RISE] |= 8'h08;
        model_cap[EDGE_ANY]  |= 8'h08;
        check_caps("toggle_high");
        clear_all();
        in_port = model_level;
        idle(4 + D);
        model_cap[EDGE_FALL] |= 8'h08;
        model_cap[EDGE_ANY]  |= 8'h08;
        check_caps("toggle_low");
    endtask

`ifdef PIO_IN_DEBOUNCE_EN
    task automatic test_debounce();
        in_port = '0;
        idle(4 + D);
        clear_all();
        bus_cycle(ADDR_IRQMASK, 1'b0, 1'b1, 32'h01);
        model_mask = 8'h01;
        in_port = 8'h01;
        idle(3);
        in_port = '0;
        idle(12);
        model_level = '0;
        bus_cycle(ADDR_DATA, 1'b1, 1'b0, 32'h0);
        compared++;
        if (rdv[0] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL glitch_data: got %h expected 00000000", rdv[0]);
        end
        check_caps("glitch");
        in_port    = 8'h01;
        address    = ADDR_DATA;
        chipselect = 1'b1;
        read       = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (n == 6) in_port = '0;
            compared++;
            if (rdv[0] !== 32'(n >= 7) || irqv[0] !== (n >= 7) || irqv[1] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL pulse edge%0d: got rd=%h irq=%b/%b expected rd=%h irq=%b/0",
                         n, rdv[0], irqv[0], irqv[1], 32'(n >= 7), (n >= 7));
            end
        end
        chipselect = 1'b0;
        read       = 1'b0;
        idle(12);
        for (int i = 0; i < 3; i++) model_cap[i] |= 8'h01;
        check_caps("pulse");
    endtask
`endif

    task automatic test_reset_held();
        logic exp_bit;
        in_port = 8'h01;
        reset   = 1'b1;
        idle(2);
        reset      = 1'b0;
        model_mask = '0;
        address    = ADDR_EDGECAP;
        chipselect = 1'b1;
        read       = 1'b1;
        for (int n = 1; n <= 5 + D; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                exp_bit = (i != EDGE_FALL) && (n >= 4 + D);
                compared++;
                if (rdv[i] !== 32'(exp_bit)) begin
                    mismatched++;
                    $display("[TB] FAIL reset_held edge%0d mode%0d: got %h expected %h", n, i, rdv[i], 32'(exp_bit));
                end
            end
        end
        chipselect = 1'b0;
        read       = 1'b0;
        model_cap[EDGE_RISE] = 8'h01;
        model_cap[EDGE_FALL] = 8'h00;
        model_cap[EDGE_ANY]  = 8'h01;
        model_level = 8'h01;
        check_caps("reset_held");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] rise_bits;
        logic [WIDTH-1:0] fall_bits;
        logic [31:0]      wd;
        for (int it = 0; it < 24; it++) begin
            wd = $urandom;
            bus_cycle(ADDR_IRQMASK, 1'b0, 1'b1, wd);
            model_mask = wd[WIDTH-1:0];
            v = WIDTH'($urandom);
            in_port = v;
            idle(4 + D);
            rise_bits = v & ~model_level;
            fall_bits = ~v & model_level;
            model_cap[EDGE_RISE] |= rise_bits;
            model_cap[EDGE_FALL] |= fall_bits;
            model_cap[EDGE_ANY]  |= rise_bits | fall_bits;
            model_level = v;
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                bus_cycle(ADDR_EDGECAP, 1'b0, 1'b1, wd);
                for (int i = 0; i < 3; i++) model_cap[i] &= ~wd[WIDTH-1:0];
            end
            bus_cycle(ADDR_RSVD, 1'b0, 1'b1, $urandom);
            bus_cycle(ADDR_DATA, 1'b1, 1'b0, 32'h0);
            compared++;
            if (rdv[0] !== 32'(v) || rdv[2] !== 32'(v)) begin
                mismatched++;
                $display("[TB] FAIL rand_data it%0d: got %h/%h expected %h", it, rdv[0], rdv[2], 32'(v));
            end
            bus_cycle(ADDR_IRQMASK, 1'b1, 1'b0, 32'h0);
            compared++;
            if (rdv[1] !== 32'(model_mask)) begin
                mismatched++;
                $display("[TB] FAIL rand_mask it%0d: got %h expected %h", it, rdv[1], 32'(model_mask));
            end
            bus_cycle(ADDR_RSVD, 1'b1, 1'b0, 32'h0);
            compared++;
            if (rdv[2] !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL rand_rsvd it%0d: got %h expected 00000000", it, rdv[2]);
            end
            check_caps("rand");
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        in_port    = '0;
        $display("[TB] starting, debounce cycles in effect = %0d", D);
        test_reset();
        test_latency();
        test_w1c();
        test_set_wins();
        test_any_edge();
`ifdef PIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
